// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, baud table, divisor helper and the
// receiver state type.
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } rx_state_t;

  // Baud rate selected by the 3-bit baud_select code.
  function automatic int unsigned baud_rate(input logic [2:0] sel);
    int unsigned rate;
    case (sel)
      3'd0:    rate = 300;
      3'd1:    rate = 1200;
      3'd2:    rate = 4800;
      3'd3:    rate = 9600;
      3'd4:    rate = 19200;
      3'd5:    rate = 38400;
      3'd6:    rate = 57600;
      default: rate = 115200;
    endcase
    return rate;
  endfunction

  // Clock cycles per sample tick, rounded to nearest.
  function automatic int unsigned baud_divisor(input int unsigned clk_hz,
                                               input logic [2:0] sel,
                                               input int unsigned os);
    int unsigned denom;
    denom = os * baud_rate(sel);
    return (clk_hz + denom / 2) / denom;
  endfunction

endpackage

// File: rtl/uart_baud_controller.sv
// Sample-tick generator: latches the divisor for the selected baud rate while
// allowed, and emits a one-clock sample_tick every divisor clocks.
module uart_baud_controller
  import uart_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int OVERSAMPLE  = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [2:0] baud_select,
  input  logic       latch_en,
  input  logic       restart,
  output logic       sample_tick
);

  // Slowest rate has the largest divisor, so it sets the counter width.
  localparam int DIV_W = $clog2(baud_divisor(CLK_FREQ_HZ, 3'd0, OVERSAMPLE) + 1);

  logic [DIV_W-1:0] div_table [8];
  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] cnt_q;
  logic             wrap;

  for (genvar g = 0; g < 8; g++) begin : g_div
    localparam logic [DIV_W-1:0] DIV = DIV_W'(baud_divisor(CLK_FREQ_HZ, 3'(g), OVERSAMPLE));
    assign div_table[g] = DIV;
  end

  assign wrap        = (cnt_q >= div_q - DIV_W'(1));
  assign sample_tick = wrap && !restart;

  // Divisor latch and free-running tick counter; restart realigns the phase.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_q <= DIV_W'(1);
      cnt_q <= '0;
    end else begin
      if (latch_en) div_q <= div_table[baud_select];
      if (restart || wrap) cnt_q <= '0;
      else                 cnt_q <= cnt_q + DIV_W'(1);
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver with configurable frame format, 3-sample majority voting,
// false-start rejection and an output FIFO with overrun detection.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int DATA_BITS   = 8,
  parameter int PARITY_MODE = 1,
  parameter int STOP_BITS   = 1,
  parameter int OVERSAMPLE  = 16,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [2:0]           baud_select,
  input  logic                 Rx_EN,
  input  logic                 RxD,
  input  logic                 Rx_READY,
  output logic [DATA_BITS-1:0] Rx_DATA,
  output logic                 Rx_VALID,
  output logic                 Rx_PERROR,
  output logic                 Rx_FERROR,
  output logic                 Rx_OVERRUN
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [TW-1:0] T_S0   = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] T_S1   = TW'(OVERSAMPLE / 2);
  localparam logic [TW-1:0] T_S2   = TW'(OVERSAMPLE / 2 + 1);
  localparam logic [TW-1:0] T_LAST = TW'(OVERSAMPLE - 1);

  logic                 rx_meta, rx_sync;
  logic                 sample_tick;
  rx_state_t            state_q, state_d;
  logic [TW-1:0]        tick_cnt;
  logic [BW-1:0]        bit_cnt;
  logic                 stop_idx;
  logic                 samp0, samp1;
  logic [DATA_BITS-1:0] data_q;
  logic                 perr_q, ferr_q;
  logic                 push_req;
  logic                 start_det, decide, maj, frame_done;

  logic [DATA_BITS-1:0] mem_data [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] mem_perr, mem_ferr;
  logic [AW:0]          wr_ptr, rd_ptr;
  logic                 fifo_empty, fifo_full, pop, push_fire;

  // Two-flop synchroniser on the asynchronous serial line, idling high.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= RxD;
      rx_sync <= rx_meta;
    end
  end

  uart_baud_controller #(
    .CLK_FREQ_HZ(CLK_FREQ_HZ),
    .OVERSAMPLE (OVERSAMPLE)
  ) u_baud (
    .clk        (clk),
    .reset_n    (reset_n),
    .baud_select(baud_select),
    .latch_en   (state_q == ST_IDLE),
    .restart    (start_det),
    .sample_tick(sample_tick)
  );

  assign start_det  = (state_q == ST_IDLE) && Rx_EN && !rx_sync;
  assign decide     = sample_tick && (state_q != ST_IDLE) && (tick_cnt == T_S2);
  assign maj        = (samp0 & samp1) | (samp0 & rx_sync) | (samp1 & rx_sync);
  assign frame_done = Rx_EN && decide && (state_q == ST_STOP) &&
                      (stop_idx == 1'(STOP_BITS - 1));

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic; transitions happen at each bit's majority decision.
  always_comb begin
    state_d = state_q;
    if (!Rx_EN) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:   if (!rx_sync) state_d = ST_START;
        ST_START:  if (decide) state_d = maj ? ST_IDLE : ST_DATA;
        ST_DATA:   if (decide && bit_cnt == BW'(DATA_BITS - 1))
                     state_d = (PARITY_MODE == PAR_NONE) ? ST_STOP : ST_PARITY;
        ST_PARITY: if (decide) state_d = ST_STOP;
        ST_STOP:   if (decide && stop_idx == 1'(STOP_BITS - 1)) state_d = ST_IDLE;
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  // Bit timing, sample capture and frame assembly.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tick_cnt <= '0;
      bit_cnt  <= '0;
      stop_idx <= 1'b0;
      samp0    <= 1'b1;
      samp1    <= 1'b1;
      data_q   <= '0;
      perr_q   <= 1'b0;
      ferr_q   <= 1'b0;
      push_req <= 1'b0;
    end else begin
      push_req <= frame_done;
      if (start_det) begin
        tick_cnt <= '0;
        bit_cnt  <= '0;
        stop_idx <= 1'b0;
        perr_q   <= 1'b0;
        ferr_q   <= 1'b0;
      end else if (sample_tick && state_q != ST_IDLE) begin
        tick_cnt <= (tick_cnt == T_LAST) ? '0 : tick_cnt + TW'(1);
        if (tick_cnt == T_S0) samp0 <= rx_sync;
        if (tick_cnt == T_S1) samp1 <= rx_sync;
        if (decide) begin
          case (state_q)
            ST_DATA: begin
              data_q  <= {maj, data_q[DATA_BITS-1:1]};
              bit_cnt <= bit_cnt + BW'(1);
            end
            ST_PARITY: perr_q <= (PARITY_MODE == PAR_ODD) ? ~(^data_q ^ maj) : (^data_q ^ maj);
            ST_STOP: begin
              ferr_q   <= ferr_q | ~maj;
              stop_idx <= stop_idx + 1'b1;
            end
            default: ;
          endcase
        end
      end
    end
  end

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop        = !fifo_empty && Rx_READY;
  assign push_fire  = push_req && Rx_EN && (!fifo_full || pop);

  // FIFO storage; only written on an accepted push.
  always_ff @(posedge clk) begin
    if (push_fire) begin
      mem_data[wr_ptr[AW-1:0]] <= data_q;
      mem_perr[wr_ptr[AW-1:0]] <= perr_q;
      mem_ferr[wr_ptr[AW-1:0]] <= ferr_q;
    end
  end

  // FIFO pointers and the sticky overrun flag, which Rx_EN low clears.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      Rx_OVERRUN <= 1'b0;
    end else begin
      if (push_fire) wr_ptr <= wr_ptr + 1'b1;
      if (pop)       rd_ptr <= rd_ptr + 1'b1;
      if (!Rx_EN)                                  Rx_OVERRUN <= 1'b0;
      else if (push_req && fifo_full && !pop)      Rx_OVERRUN <= 1'b1;
    end
  end

  assign Rx_VALID  = !fifo_empty;
  assign Rx_DATA   = fifo_empty ? '0   : mem_data[rd_ptr[AW-1:0]];
  assign Rx_PERROR = fifo_empty ? 1'b0 : mem_perr[rd_ptr[AW-1:0]];
  assign Rx_FERROR = fifo_empty ? 1'b0 : mem_ferr[rd_ptr[AW-1:0]];

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: a default 8E1 instance and a 7O2 instance
// run in parallel; monitors compare each popped entry with queued expectations.
module tb_uart_rx_fifo;

  localparam int BIT_CLKS = 432;

  typedef struct packed {
    logic [8:0] data;
    logic       perr;
    logic       ferr;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n1, rst_n2;
  logic       rx_en1, rx_en2, rxd1, rxd2, ready1, ready2;
  logic [7:0] data1;
  logic [6:0] data2;
  logic       valid1, perr1, ferr1, ovr1;
  logic       valid2, perr2, ferr2, ovr2;

  exp_t q1[$];
  exp_t q2[$];
  int   checks = 0;
  int   errors = 0;

  always #10 clk = ~clk;

  uart_rx_fifo dut1 (
    .clk(clk), .reset_n(rst_n1), .baud_select(3'b111), .Rx_EN(rx_en1), .RxD(rxd1),
    .Rx_READY(ready1), .Rx_DATA(data1), .Rx_VALID(valid1), .Rx_PERROR(perr1),
    .Rx_FERROR(ferr1), .Rx_OVERRUN(ovr1)
  );

  uart_rx_fifo #(.DATA_BITS(7), .PARITY_MODE(2), .STOP_BITS(2)) dut2 (
    .clk(clk), .reset_n(rst_n2), .baud_select(3'b111), .Rx_EN(rx_en2), .RxD(rxd2),
    .Rx_READY(ready2), .Rx_DATA(data2), .Rx_VALID(valid2), .Rx_PERROR(perr2),
    .Rx_FERROR(ferr2), .Rx_OVERRUN(ovr2)
  );

  function automatic logic [15:0] make_frame(input logic [8:0] d, input int nd,
                                             input logic par_bit, input logic stop_val,
                                             input int ns, output int n);
    logic [15:0] bits;
    int idx;
    bits = '1;
    bits[0] = 1'b0;
    for (int i = 0; i < nd; i++) bits[1 + i] = d[i];
    idx = nd + 1;
    bits[idx] = par_bit;
    idx++;
    for (int s = 0; s < ns; s++) begin
      bits[idx] = stop_val;
      idx++;
    end
    n = idx;
    return bits;
  endfunction

  task automatic applyStimulus(input int which, input logic [15:0] bits, input int n,
                               input int glitch_bit);
    logic lv;
    for (int b = 0; b < n; b++) begin
      for (int c = 0; c < BIT_CLKS; c++) begin
        lv = bits[b];
        if (b == glitch_bit && c >= 206 && c < 226) lv = ~lv;
        if (which == 1) rxd1 = lv;
        else            rxd2 = lv;
        @(negedge clk);
      end
    end
    if (which == 1) rxd1 = 1'b1;
    else            rxd2 = 1'b1;
  endtask

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor for dut1: every handshake pops one expectation and compares.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (valid1 && ready1) begin
        checks++;
        if (q1.size() == 0) begin
          errors++;
          $display("[TB] FAIL dut1_unexpected: got data=0x%0h perr=%0b ferr=%0b, want no entry",
                   data1, perr1, ferr1);
        end else begin
          e = q1.pop_front();
          if ({1'b0, data1} !== e.data || perr1 !== e.perr || ferr1 !== e.ferr) begin
            errors++;
            $display("[TB] FAIL dut1_entry: got data=0x%0h perr=%0b ferr=%0b, want data=0x%0h perr=%0b ferr=%0b",
                     data1, perr1, ferr1, e.data, e.perr, e.ferr);
          end
        end
      end
    end
  end

  // Monitor for dut2.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (valid2 && ready2) begin
        checks++;
        if (q2.size() == 0) begin
          errors++;
          $display("[TB] FAIL dut2_unexpected: got data=0x%0h perr=%0b ferr=%0b, want no entry",
                   data2, perr2, ferr2);
        end else begin
          e = q2.pop_front();
          if ({2'b0, data2} !== e.data || perr2 !== e.perr || ferr2 !== e.ferr) begin
            errors++;
            $display("[TB] FAIL dut2_entry: got data=0x%0h perr=%0b ferr=%0b, want data=0x%0h perr=%0b ferr=%0b",
                     data2, perr2, ferr2, e.data, e.perr, e.ferr);
          end
        end
      end
    end
  end

  task automatic dut1_seq();
    logic [15:0] bits;
    int n;
    logic [4:0] par_tbl;
    par_tbl = 5'b01011;
    // Good 0x85 frame, even parity bit 1.
    q1.push_back(exp_t'{9'h085, 1'b0, 1'b0});
    bits = make_frame(9'h085, 8, 1'b1, 1'b1, 1, n);
    applyStimulus(1, bits, n, -1);
    // Wrong parity bit.
    q1.push_back(exp_t'{9'h085, 1'b1, 1'b0});
    bits = make_frame(9'h085, 8, 1'b0, 1'b1, 1, n);
    applyStimulus(1, bits, n, -1);
    // Stop bit low, then a clean 0x3C after an idle gap.
    q1.push_back(exp_t'{9'h085, 1'b0, 1'b1});
    bits = make_frame(9'h085, 8, 1'b1, 1'b0, 1, n);
    applyStimulus(1, bits, n, -1);
    idle(2 * BIT_CLKS);
    q1.push_back(exp_t'{9'h03C, 1'b0, 1'b0});
    bits = make_frame(9'h03C, 8, 1'b0, 1'b1, 1, n);
    applyStimulus(1, bits, n, -1);
    // False start: three ticks low.
    rxd1 = 1'b0;
    idle(81);
    rxd1 = 1'b1;
    idle(3 * BIT_CLKS);
    checkOutput("false_start_valid", 16'(valid1), 16'h0);
    // Short glitch inside D0 must not flip it.
    q1.push_back(exp_t'{9'h085, 1'b0, 1'b0});
    bits = make_frame(9'h085, 8, 1'b1, 1'b1, 1, n);
    applyStimulus(1, bits, n, 1);
    // Overrun: five back-to-back frames with no consumer.
    ready1 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i < 4) q1.push_back(exp_t'{9'(i + 1), 1'b0, 1'b0});
      bits = make_frame(9'(i + 1), 8, par_tbl[i], 1'b1, 1, n);
      applyStimulus(1, bits, n, -1);
    end
    checkOutput("overrun_set", 16'(ovr1), 16'h1);
    checkOutput("full_valid", 16'(valid1), 16'h1);
    checkOutput("full_head", 16'(data1), 16'h01);
    ready1 = 1'b1;
    idle(10);
    checkOutput("drained_valid", 16'(valid1), 16'h0);
    checkOutput("overrun_held", 16'(ovr1), 16'h1);
    rx_en1 = 1'b0;
    idle(2);
    rx_en1 = 1'b1;
    idle(2);
    checkOutput("overrun_cleared", 16'(ovr1), 16'h0);
  endtask

  task automatic dut2_seq();
    logic [15:0] bits;
    int n;
    // 7O2 frame 0x55, odd parity bit 1.
    q2.push_back(exp_t'{9'h055, 1'b0, 1'b0});
    bits = make_frame(9'h055, 7, 1'b1, 1'b1, 2, n);
    applyStimulus(2, bits, n, -1);
    // Hold 0x33 in the FIFO, then reset mid-DATA of the next frame.
    ready2 = 1'b0;
    bits = make_frame(9'h033, 7, 1'b1, 1'b1, 2, n);
    applyStimulus(2, bits, n, -1);
    idle(4);
    checkOutput("dut2_held_valid", 16'(valid2), 16'h1);
    checkOutput("dut2_held_data", 16'(data2), 16'h33);
    bits = make_frame(9'h012, 7, 1'b1, 1'b1, 2, n);
    applyStimulus(2, bits, 4, -1);
    rst_n2 = 1'b0;
    idle(3);
    checkOutput("dut2_reset_valid", 16'(valid2), 16'h0);
    checkOutput("dut2_reset_data", 16'(data2), 16'h0);
    rst_n2 = 1'b1;
    ready2 = 1'b1;
    idle(BIT_CLKS);
    q2.push_back(exp_t'{9'h012, 1'b0, 1'b0});
    applyStimulus(2, bits, n, -1);
  endtask

  initial begin
    rst_n1 = 1'b0; rst_n2 = 1'b0;
    rx_en1 = 1'b1; rx_en2 = 1'b1;
    rxd1 = 1'b1; rxd2 = 1'b1;
    ready1 = 1'b1; ready2 = 1'b1;
    idle(5);
    checkOutput("reset_valid", 16'(valid1), 16'h0);
    checkOutput("reset_data", 16'(data1), 16'h0);
    checkOutput("reset_perr", 16'(perr1), 16'h0);
    checkOutput("reset_ferr", 16'(ferr1), 16'h0);
    checkOutput("reset_overrun", 16'(ovr1), 16'h0);
    checkOutput("reset_valid2", 16'(valid2), 16'h0);
    rst_n1 = 1'b1; rst_n2 = 1'b1;
    idle(5);
    fork
      dut1_seq();
      dut2_seq();
    join
    for (int i = 0; i < 2000 && (q1.size() != 0 || q2.size() != 0); i++) @(negedge clk);
    checkOutput("dut1_all_received", 16'(q1.size()), 16'h0);
    checkOutput("dut2_all_received", 16'(q2.size()), 16'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Parametrised UART receiver: next generation of the fixed 8-bit/even-parity `uart_receiver`. Adds configurable frame format (data width, parity mode, stop bits), 3-sample majority voting, false-start rejection, an output FIFO with valid/ready handshake, and overrun detection. Sits between the RxD pin and the byte consumer in the receive path, driven by the same `baud_select` encoding as the existing transmitter/receiver pair.

## Interface
- `CLK_FREQ_HZ`, 50_000_000, system clock frequency.
- `DATA_BITS`, 8, data bits per frame, 5..9.
- `PARITY_MODE`, 1, 0 = none, 1 = even, 2 = odd.
- `STOP_BITS`, 1, 1 or 2.
- `OVERSAMPLE`, 16, sample ticks per bit, even, ≥ 8.
- `FIFO_DEPTH`, 4, entries, power of 2, ≥ 2.
- `clk` in 1: single clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `baud_select` in 3: 000..111 = 300, 1200, 4800, 9600, 19200, 38400, 57600, 115200 baud.
- `Rx_EN` in 1: receiver enable.
- `RxD` in 1: serial line, asynchronous, idle high.
- `Rx_READY` in 1: consumer accepts head entry.
- `Rx_DATA` out DATA_BITS: head entry data, LSB = first received bit.
- `Rx_VALID` out 1: FIFO non-empty.
- `Rx_PERROR` out 1: head entry parity error (0 when PARITY_MODE = 0).
- `Rx_FERROR` out 1: head entry framing error.
- `Rx_OVERRUN` out 1: sticky, a frame was dropped because the FIFO was full.

## Operation
- RxD passes through a 2-FF synchroniser (reset value 1); all logic uses the synchronised value.
- Tick generator: divisor = round(CLK_FREQ_HZ / (OVERSAMPLE × baud)). It is latched only in IDLE, so a `baud_select` change mid-frame takes effect from the next frame.
- Tick counter restarts on the IDLE→START transition (falling edge of synchronised RxD).
- Bit value = majority of samples at ticks OVERSAMPLE/2−1, OVERSAMPLE/2, OVERSAMPLE/2+1 of each bit; the bit period is OVERSAMPLE ticks.
- FSM states:
  - IDLE: wait for RxD = 0 with Rx_EN = 1.
  - START: majority 1 means false start, return to IDLE with no push; majority 0 goes to DATA.
  - DATA: DATA_BITS bits, LSB first.
  - PARITY: skipped if mode 0. PERROR = received parity ≠ expected (even: XOR of data ^ parity must be 0; odd: must be 1).
  - STOP: STOP_BITS bits. FERROR if any stop-bit majority is 0.
- Push: in the cycle after the last stop-bit decision, {data, PERROR, FERROR} is written to the FIFO and the FSM returns to IDLE at once (mid-stop-bit), so back-to-back frames resynchronise.
- FIFO:
  - Pop when Rx_VALID & Rx_READY. A pop while empty is ignored.
  - Push while full with a simultaneous pop is accepted.
  - Push while full without a pop drops the frame and sets Rx_OVERRUN.
- Outputs show the head entry combinationally from FIFO storage. Rx_DATA, Rx_PERROR and Rx_FERROR are forced to 0 when empty.
- Rx_EN = 0:
  - FSM goes synchronously to IDLE and any partial frame is discarded.
  - Rx_OVERRUN clears.
  - FIFO contents are retained and remain readable.
- Reset: FSM IDLE, FIFO empty, all outputs 0, synchroniser 1. Reset mid-frame discards the frame.

## Timing
- Rx_VALID rises 1 clk after the push cycle, i.e. 2 clks after the final stop-bit majority decision.
- A pop updates the head outputs on the next clk edge. Rx_VALID falls on the edge that pops the last entry.
- RxD-to-FSM latency is 2 clks (synchroniser). Start detection is 1 clk after that.
- Example: at 115200 baud and 50 MHz, divisor = 27, bit = 432 clks; an 8E1 frame is 11 bits = 4752 clks.

## Structure
- Package `uart_pkg`:
  - parity mode constants (`PAR_NONE`, `PAR_EVEN`, `PAR_ODD`);
  - baud table function `baud_rate(sel)`;
  - divisor function `baud_divisor(clk_hz, sel, os)`;
  - FSM state typedef.
- Sub-module `uart_baud_controller`: divisor latch, counter and one-clk `sample_tick` output. It is shared with the transmitter generation.
- FIFO stays inline: register array plus rd/wr pointers with an extra wrap bit.

## Test plan
- Defaults, `baud_select` = 111, frame 0 / 1,0,1,0,0,0,0,1 / parity 1 / stop 1 → Rx_DATA = 0x85, Rx_VALID = 1, PERROR = 0, FERROR = 0.
- Same frame with parity 0 → Rx_DATA = 0x85, PERROR = 1, FERROR = 0.
- Same frame with stop bit 0 → FERROR = 1. A following valid 0x3C frame is received cleanly.
- Idle line pulled low for 3 sample ticks (81 clks) → no push, Rx_VALID stays 0. A 1-tick glitch inside D0 does not change the majority result.
- Rx_READY = 0, five frames 0x01..0x05 back-to-back → Rx_OVERRUN = 1. Pops return 0x01..0x04 and the FIFO is then empty. Rx_EN pulse low clears OVERRUN.
- DATA_BITS = 7, PARITY_MODE = 2, STOP_BITS = 2: send 0x55 (parity 1) → 0x55 with no errors. Assert reset_n low mid-DATA → outputs 0, no entry; the next frame is received correctly.
